// File: rtl/mole_game_pkg.sv
// rtl/mole_game_pkg.sv - shared state encoding, LFSR taps and default timing for the mole game
package mole_game_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  // Right-shift Galois mask for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int DEF_GAME_SECONDS = 30;
  localparam int DEF_SEC_DIV      = 100_000_000;
  localparam int DEF_SLOT_DIV     = 1_000_000;
  localparam int DEF_WINDOW_START = 150;
  localparam int DEF_WINDOW_MIN   = 40;
  localparam int DEF_WINDOW_STEP  = 5;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/mole_game_core_pos.sv
// rtl/mole_game_core_pos.sv - free-running LFSR and no-repeat mole position picker
module mole_lfsr_pos
  import mole_game_pkg::*;
#(
  parameter int          N_HOLES   = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         HOLE_W    = $clog2(N_HOLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [HOLE_W-1:0] i_cur_pos,
  output logic [HOLE_W-1:0] o_next_pos
);

  logic [15:0] r_lfsr;
  logic [7:0]  w_cand;
  logic [7:0]  w_cur;
  logic [7:0]  w_adj;

  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= LFSR_SEED;
    else     r_lfsr <= lfsr_next(r_lfsr);
  end

  assign w_cand = r_lfsr[7:0] % 8'(N_HOLES);
  assign w_cur  = 8'(i_cur_pos);

  // Bumping a repeated candidate by one guarantees the mole always moves
  always_comb begin
    w_adj = w_cand;
    if (w_cand == w_cur) begin
      if (w_cand == 8'(N_HOLES - 1)) w_adj = 8'd0;
      else                           w_adj = w_cand + 8'd1;
    end
  end

  assign o_next_pos = i_load ? HOLE_W'(w_adj) : i_cur_pos;

endmodule

// File: rtl/mole_game_core.sv
// rtl/mole_game_core.sv - game FSM, countdown, mole window, hit/miss scoring for N holes
module mole_game_core
  import mole_game_pkg::*;
#(
  parameter int          N_HOLES      = 8,
  parameter int          SCORE_W      = 8,
  parameter int          SEC_W        = 5,
  parameter int          GAME_SECONDS = DEF_GAME_SECONDS,
  parameter int          SEC_DIV      = DEF_SEC_DIV,
  parameter int          SLOT_DIV     = DEF_SLOT_DIV,
  parameter int          WINDOW_START = DEF_WINDOW_START,
  parameter int          WINDOW_MIN   = DEF_WINDOW_MIN,
  parameter int          WINDOW_STEP  = DEF_WINDOW_STEP,
  parameter int          MISS_PENALTY = 1,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  localparam int         HOLE_W       = $clog2(N_HOLES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_guess_valid,
  input  logic [HOLE_W-1:0]  i_guess,
  output logic [HOLE_W-1:0]  o_mole_pos,
  output logic               o_mole_change,
  output logic               o_hit,
  output logic               o_miss,
  output logic               o_timeout,
  output logic [SCORE_W-1:0] o_score,
  output logic [SEC_W-1:0]   o_seconds,
  output logic               o_game_over,
  output logic               o_playing
);

  localparam int SEC_CNT_W  = $clog2(SEC_DIV);
  localparam int SLOT_CNT_W = $clog2(SLOT_DIV);
  localparam int WIN_W      = $clog2(WINDOW_START + 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [SCORE_W-1:0]  r_score;
  logic [SEC_W-1:0]    r_seconds;
  logic [HOLE_W-1:0]   r_mole_pos;
  logic [WIN_W-1:0]    r_window;
  logic [SEC_CNT_W-1:0]  r_sec_pre;
  logic [SLOT_CNT_W-1:0] r_slot_pre;
  logic [WIN_W-1:0]    r_slot_cnt;
  logic                r_mole_change;
  logic                r_hit;
  logic                r_miss;
  logic                r_timeout;

  logic              w_play;
  logic              w_sec_tick;
  logic              w_slot_tick;
  logic              w_guess;
  logic              w_hit;
  logic              w_miss;
  logic [WIN_W-1:0]  w_slot_inc;
  logic              w_expire;
  logic              w_timeout;
  logic              w_load;
  logic              w_last_sec;
  logic [HOLE_W-1:0] w_next_pos;

  assign w_play      = (r_state == S_PLAY);
  assign w_sec_tick  = w_play && (r_sec_pre == SEC_CNT_W'(SEC_DIV - 1));
  assign w_slot_tick = w_play && (r_slot_pre == SLOT_CNT_W'(SLOT_DIV - 1));
  // A restart swallows any guess presented in the same cycle
  assign w_guess     = w_play && i_guess_valid && !i_start;
  assign w_hit       = w_guess && (i_guess == r_mole_pos);
  assign w_miss      = w_guess && !w_hit;
  assign w_slot_inc  = r_slot_cnt + WIN_W'(1);
  assign w_expire    = w_slot_tick && (w_slot_inc == r_window);
  assign w_timeout   = w_expire && !w_guess && !i_start;
  assign w_load      = i_start || w_hit || w_timeout;
  assign w_last_sec  = w_sec_tick && (r_seconds == SEC_W'(1));

  mole_lfsr_pos #(
    .N_HOLES   (N_HOLES),
    .LFSR_SEED (LFSR_SEED)
  ) u_pos (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_cur_pos  (r_mole_pos),
    .o_next_pos (w_next_pos)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_OVER: if (i_start) w_state_next = S_PLAY;
      S_PLAY: begin
        if (i_start)         w_state_next = S_PLAY;
        else if (w_last_sec) w_state_next = S_OVER;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_score       <= '0;
      r_seconds     <= SEC_W'(GAME_SECONDS);
      r_mole_pos    <= '0;
      r_window      <= WIN_W'(WINDOW_START);
      r_sec_pre     <= '0;
      r_slot_pre    <= '0;
      r_slot_cnt    <= '0;
      r_mole_change <= 1'b0;
      r_hit         <= 1'b0;
      r_miss        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_mole_change <= w_load;
      r_hit         <= w_hit;
      r_miss        <= w_miss;
      r_timeout     <= w_timeout;
      r_mole_pos    <= w_next_pos;
      if (i_start) begin
        r_score    <= '0;
        r_seconds  <= SEC_W'(GAME_SECONDS);
        r_window   <= WIN_W'(WINDOW_START);
        r_sec_pre  <= '0;
        r_slot_pre <= '0;
        r_slot_cnt <= '0;
      end else if (w_play) begin
        r_sec_pre  <= w_sec_tick  ? '0 : r_sec_pre + SEC_CNT_W'(1);
        r_slot_pre <= w_slot_tick ? '0 : r_slot_pre + SLOT_CNT_W'(1);
        if (w_sec_tick) r_seconds <= r_seconds - SEC_W'(1);
        if (w_hit) begin
          if (r_score != '1) r_score <= r_score + SCORE_W'(1);
          r_window <= (r_window >= WIN_W'(WINDOW_MIN + WINDOW_STEP)) ?
                      r_window - WIN_W'(WINDOW_STEP) : WIN_W'(WINDOW_MIN);
        end else if (w_miss) begin
          r_score <= (r_score >= SCORE_W'(MISS_PENALTY)) ?
                     r_score - SCORE_W'(MISS_PENALTY) : '0;
        end
        // An expired window restarts the count even when a guess claimed the cycle
        if (w_hit || w_expire) r_slot_cnt <= '0;
        else if (w_slot_tick)  r_slot_cnt <= w_slot_inc;
      end
    end
  end

  assign o_mole_pos    = r_mole_pos;
  assign o_mole_change = r_mole_change;
  assign o_hit         = r_hit;
  assign o_miss        = r_miss;
  assign o_timeout     = r_timeout;
  assign o_score       = r_score;
  assign o_seconds     = r_seconds;
  assign o_game_over   = (r_state == S_OVER);
  assign o_playing     = w_play;

endmodule

// File: tb/tb_mole_game_core.sv
// tb/tb_mole_game_core.sv - directed scoreboard bench for mole_game_core
module tb_mole_game_core;

  localparam int GS = 3, SD = 20, SL = 4, WS = 5, WMIN = 3, WSTEP = 1;

  typedef struct {
    int pos, chg, hit, miss, to, score, sec, over, play;
    int bt, bpos, bchg, bhit, bscore, bplay;
  } exp_t;

  logic       clk, rst;
  logic       a_start, a_gv;
  logic [2:0] a_g, a_pos;
  logic       a_chg, a_hit, a_miss, a_to, a_over, a_play;
  logic [7:0] a_score;
  logic [4:0] a_sec;
  logic       b_start, b_gv;
  logic [2:0] b_g, b_pos;
  logic       b_chg, b_hit, b_miss, b_to, b_over, b_play;
  logic [7:0] b_score;
  logic [4:0] b_sec;

  int checks = 0, errors = 0;
  exp_t exp_q[$];

  logic [15:0] m_lfsr;
  logic [2:0]  m_pos, mb_pos;
  int m_state, m_score, m_sec, m_win, m_cyc, m_slot_cnt;
  int mb_score, mb_play, mb_track;

  mole_game_core #(.N_HOLES(6), .SCORE_W(8), .SEC_W(5), .GAME_SECONDS(GS), .SEC_DIV(SD),
    .SLOT_DIV(SL), .WINDOW_START(WS), .WINDOW_MIN(WMIN), .WINDOW_STEP(WSTEP),
    .MISS_PENALTY(1), .LFSR_SEED(16'hACE1)) u_dut (
    .clk(clk), .rst(rst), .i_start(a_start), .i_guess_valid(a_gv), .i_guess(a_g),
    .o_mole_pos(a_pos), .o_mole_change(a_chg), .o_hit(a_hit), .o_miss(a_miss),
    .o_timeout(a_to), .o_score(a_score), .o_seconds(a_sec), .o_game_over(a_over),
    .o_playing(a_play));

  // Long-game instance so 256 consecutive hits fit inside one game
  mole_game_core #(.N_HOLES(6), .SCORE_W(8), .SEC_W(5), .GAME_SECONDS(GS), .SEC_DIV(200),
    .SLOT_DIV(SL), .WINDOW_START(WS), .WINDOW_MIN(WMIN), .WINDOW_STEP(WSTEP),
    .MISS_PENALTY(1), .LFSR_SEED(16'hACE1)) u_sat (
    .clk(clk), .rst(rst), .i_start(b_start), .i_guess_valid(b_gv), .i_guess(b_g),
    .o_mole_pos(b_pos), .o_mole_change(b_chg), .o_hit(b_hit), .o_miss(b_miss),
    .o_timeout(b_to), .o_score(b_score), .o_seconds(b_sec), .o_game_over(b_over),
    .o_playing(b_play));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    fb = l[0];
    l = l >> 1;
    if (fb) l = l ^ 16'hB400;
    return l;
  endfunction

  function automatic logic [2:0] next_hole(input logic [15:0] l, input logic [2:0] cur);
    int c;
    c = int'(l[7:0]) % 6;
    if (c == int'(cur)) c = (c + 1) % 6;
    return 3'(c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_step(output exp_t e);
    int sec_t, slot_t, expire, hit, miss, to, chg;
    hit = 0; miss = 0; to = 0; chg = 0;
    e.bhit = 0; e.bchg = 0;
    if (rst) begin
      m_state = 0; m_score = 0; m_sec = GS; m_pos = 0; m_win = WS;
      m_cyc = 0; m_slot_cnt = 0; m_lfsr = 16'hACE1;
      mb_pos = 0; mb_score = 0; mb_play = 0;
    end else begin
      if (a_start) begin
        m_state = 1; m_score = 0; m_sec = GS; m_win = WS; m_cyc = 0; m_slot_cnt = 0;
        m_pos = next_hole(m_lfsr, m_pos); chg = 1;
      end else if (m_state == 1) begin
        sec_t  = ((m_cyc % SD) == SD - 1) ? 1 : 0;
        slot_t = ((m_cyc % SL) == SL - 1) ? 1 : 0;
        m_cyc++;
        expire = (slot_t != 0 && m_slot_cnt + 1 == m_win) ? 1 : 0;
        if (a_gv) begin
          if (int'(a_g) == int'(m_pos)) begin
            hit = 1; chg = 1;
            if (m_score < 255) m_score++;
            m_win = (m_win - WSTEP < WMIN) ? WMIN : m_win - WSTEP;
            m_pos = next_hole(m_lfsr, m_pos);
          end else begin
            miss = 1;
            m_score = (m_score < 1) ? 0 : m_score - 1;
          end
        end else if (expire != 0) begin
          to = 1; chg = 1;
          m_pos = next_hole(m_lfsr, m_pos);
        end
        if (hit != 0 || expire != 0) m_slot_cnt = 0;
        else if (slot_t != 0)        m_slot_cnt++;
        if (sec_t != 0) begin
          m_sec--;
          if (m_sec == 0) m_state = 2;
        end
      end
      if (b_start) begin
        mb_pos = next_hole(m_lfsr, mb_pos); mb_score = 0; mb_play = 1; e.bchg = 1;
      end else if (mb_play != 0 && b_gv && b_g == mb_pos) begin
        e.bhit = 1; e.bchg = 1;
        if (mb_score < 255) mb_score++;
        mb_pos = next_hole(m_lfsr, mb_pos);
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
    e.pos = int'(m_pos); e.chg = chg; e.hit = hit; e.miss = miss; e.to = to;
    e.score = m_score; e.sec = m_sec; e.over = (m_state == 2) ? 1 : 0;
    e.play = (m_state == 1) ? 1 : 0;
    e.bt = mb_track; e.bpos = int'(mb_pos); e.bscore = mb_score; e.bplay = mb_play;
  endtask

  task automatic tick();
    exp_t e;
    model_step(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("pos", a_pos, e.pos);
    chk("mole_change", a_chg, e.chg);
    chk("hit", a_hit, e.hit);
    chk("miss", a_miss, e.miss);
    chk("timeout", a_to, e.to);
    chk("score", a_score, e.score);
    chk("seconds", a_sec, e.sec);
    chk("game_over", a_over, e.over);
    chk("playing", a_play, e.play);
    if (e.bt != 0) begin
      chk("b_pos", b_pos, e.bpos);
      chk("b_change", b_chg, e.bchg);
      chk("b_hit", b_hit, e.bhit);
      chk("b_score", b_score, e.bscore);
      chk("b_playing", b_play, e.bplay);
      chk("b_miss", b_miss, 0);
      chk("b_timeout", b_to, 0);
      chk("b_game_over", b_over, 0);
      chk("b_seconds_live", (b_sec != 0) ? 1 : 0, 1);
    end
  endtask

  task automatic wait_timeout(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!a_to && n < 40);
    chk("timeout_seen", a_to, 1);
  endtask

  initial begin
    int n;
    logic [2:0] old;
    int s0;
    rst = 1'b1; a_start = 0; a_gv = 0; a_g = 0; b_start = 0; b_gv = 0; b_g = 0;
    mb_track = 1;

    tick(); tick();
    rst = 1'b0;
    chk("rst_score", a_score, 0);
    chk("rst_seconds", a_sec, GS);
    chk("rst_pos", a_pos, 0);
    chk("rst_playing", a_play, 0);
    chk("rst_over", a_over, 0);

    a_start = 1; tick(); a_start = 0;
    chk("start_playing", a_play, 1);
    chk("start_seconds", a_sec, GS);
    chk("start_change", a_chg, 1);
    chk("start_pos_range", (a_pos < 6) ? 1 : 0, 1);
    repeat (59) tick();
    chk("e59_playing", a_play, 1);
    chk("e59_seconds", a_sec, 1);
    tick();
    chk("e60_seconds", a_sec, 0);
    chk("e60_over", a_over, 1);

    a_start = 1; tick(); a_start = 0;
    for (int i = 0; i < 5; i++) begin
      a_gv = 1; a_g = m_pos; old = m_pos;
      tick();
      chk("hit_pulse", a_hit, 1);
      chk("hit_score", a_score, i + 1);
      chk("hit_change", a_chg, 1);
      chk("hit_pos_moved", (a_pos != old) ? 1 : 0, 1);
    end
    a_gv = 0;
    wait_timeout(n);
    wait_timeout(n);
    chk("window_floor_period", n, WMIN * SL);

    a_start = 1; tick(); a_start = 0;
    a_gv = 1; a_g = 3'((int'(m_pos) + 1) % 6); tick();
    chk("miss_at_zero", a_miss, 1);
    chk("miss_floor", a_score, 0);
    a_g = m_pos; tick();
    chk("hit_then", a_score, 1);
    a_g = 3'((int'(m_pos) + 2) % 6); tick();
    chk("miss_after_hit", a_score, 0);
    a_g = 3'd7; tick();
    chk("miss_out_of_range", a_miss, 1);
    a_gv = 0;

    a_start = 1; tick(); a_start = 0;
    wait_timeout(n);
    chk("timeout_period_first", n, WS * SL);
    wait_timeout(n);
    chk("timeout_period_second", n, WS * SL);
    chk("timeout_score", a_score, 0);

    a_start = 1; tick(); a_start = 0;
    repeat (19) tick();
    a_gv = 1; a_g = m_pos; tick(); a_gv = 0;
    chk("guess_beats_timeout_hit", a_hit, 1);
    chk("guess_beats_timeout_to", a_to, 0);

    n = 0;
    while (!a_over && n < 100) begin tick(); n++; end
    chk("reach_over", a_over, 1);
    s0 = m_score; old = m_pos;
    a_gv = 1; a_g = m_pos; tick();
    a_g = 3'((int'(m_pos) + 1) % 6); tick();
    a_gv = 0;
    chk("over_no_hit", a_hit, 0);
    chk("over_no_miss", a_miss, 0);
    chk("over_score_frozen", a_score, s0);
    chk("over_pos_held", a_pos, old);
    a_start = 1; tick(); a_start = 0;
    chk("restart_playing", a_play, 1);
    chk("restart_score", a_score, 0);
    chk("restart_seconds", a_sec, GS);

    b_start = 1; tick(); b_start = 0;
    for (int i = 1; i <= 256; i++) begin
      b_gv = 1; b_g = mb_pos;
      tick();
      if (i == 255) chk("sat_reach_255", b_score, 255);
    end
    b_gv = 0;
    chk("sat_hit_pulse", b_hit, 1);
    chk("sat_hold_255", b_score, 255);
    mb_track = 0;

    a_start = 1; tick(); a_start = 0;
    a_gv = 1; a_g = m_pos; tick();
    a_g = m_pos; tick();
    a_gv = 0;
    chk("pre_reset_score", a_score, 2);
    rst = 1; tick(); rst = 0;
    chk("midgame_rst_playing", a_play, 0);
    chk("midgame_rst_over", a_over, 0);
    chk("midgame_rst_score", a_score, 0);
    chk("midgame_rst_seconds", a_sec, GS);
    chk("midgame_rst_pos", a_pos, 0);
    chk("midgame_rst_pulses", {a_chg, a_hit, a_miss, a_to}, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
